turn_manager: RTL



---
 rtl/turn_manager.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/turn_manager.sv
// Two-player turn controller: debounced centre button, per-turn seconds countdown,
// timeout strikes, game-over decision, LED turn indicator and BCD digits for display.
module turn_manager #(
  parameter int unsigned CLK_HZ          = 100_000_000,
  parameter int unsigned TURN_SECONDS    = 120,
  parameter int unsigned HOLD_SECONDS    = 3,
  parameter int unsigned MAX_STRIKES     = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btnC,
  output logic       player,
  output logic [7:0] seconds_left,
  output logic [3:0] bcd_min,
  output logic [3:0] bcd_sec_tens,
  output logic [3:0] bcd_sec_ones,
  output logic       timeout_pulse,
  output logic [1:0] strikes_p0,
  output logic [1:0] strikes_p1,
  output logic       game_over,
  output logic       winner,
  output logic [1:0] led
);

  typedef enum logic [1:0] {IDLE, RUN, EXPIRED, GAME_OVER} state_e;

  localparam logic [31:0] PRESC_MAX    = 32'(CLK_HZ - 1);
  localparam logic [31:0] LOCK_RELOAD  = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]  TURN_RELOAD  = 8'(TURN_SECONDS);
  localparam logic [7:0]  HOLD_RELOAD  = 8'(HOLD_SECONDS);
  localparam logic [1:0]  STRIKE_LIMIT = 2'(MAX_STRIKES);

  state_e      state_q, state_d;
  logic        player_q, player_d;
  logic        winner_q, winner_d;
  logic        pulse_q, pulse_d;
  logic        blink_q, blink_d;
  logic [7:0]  secs_q, secs_d;
  logic [7:0]  hold_q, hold_d;
  logic [31:0] presc_q, presc_d;
  logic [31:0] lock_q, lock_d;
  logic [1:0]  strikes_q [2];
  logic [1:0]  strikes_d [2];
  logic [2:0]  sync_q;

  logic       press, accept, counting, tick;
  logic [1:0] strike_next;
  logic [7:0] min_full, rem_sec;

  // sync_q[1:0] is the two-flop synchronizer; sync_q[2] is the edge-detect history.
  assign press    = sync_q[1] & ~sync_q[2];
  assign accept   = press && (lock_q == '0);
  assign counting = (state_q == RUN) || (state_q == EXPIRED);
  assign tick     = counting && (presc_q == PRESC_MAX);
  assign strike_next = (strikes_q[player_q] == 2'd3) ? 2'd3 : strikes_q[player_q] + 2'd1;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path can infer a latch.
    state_d   = state_q;
    player_d  = player_q;
    winner_d  = winner_q;
    pulse_d   = 1'b0;
    blink_d   = blink_q;
    secs_d    = secs_q;
    hold_d    = hold_q;
    presc_d   = presc_q;
    strikes_d = strikes_q;
    lock_d    = lock_q;

    if (accept)             lock_d = LOCK_RELOAD;
    else if (lock_q != '0)  lock_d = lock_q - 32'd1;

    if (counting) presc_d = tick ? '0 : presc_q + 32'd1;

    unique case (state_q)
      IDLE: if (accept) begin
        state_d  = RUN;
        player_d = 1'b0;
        secs_d   = TURN_RELOAD;
        presc_d  = '0;
      end
      RUN: begin
        // A press in the same cycle as a tick takes priority: the turn simply passes.
        if (accept) begin
          player_d = ~player_q;
          secs_d   = TURN_RELOAD;
          presc_d  = '0;
        end else if (tick) begin
          if (secs_q == 8'd1) begin
            secs_d                = '0;
            pulse_d               = 1'b1;
            strikes_d[player_q]   = strike_next;
            if (strike_next == STRIKE_LIMIT) begin
              state_d  = GAME_OVER;
              winner_d = ~player_q;
            end else begin
              state_d = EXPIRED;
              hold_d  = HOLD_RELOAD;
              blink_d = 1'b1;
            end
          end else if (secs_q != '0) begin
            secs_d = secs_q - 8'd1;
          end
        end
      end
      EXPIRED: if (tick) begin
        blink_d = ~blink_q;
        if (hold_q <= 8'd1) begin
          state_d  = RUN;
          player_d = ~player_q;
          secs_d   = TURN_RELOAD;
          presc_d  = '0;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      GAME_OVER: if (accept) begin
        state_d   = IDLE;
        player_d  = 1'b0;
        winner_d  = 1'b0;
        secs_d    = TURN_RELOAD;
        strikes_d = '{default: 2'd0};
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      player_q  <= 1'b0;
      winner_q  <= 1'b0;
      pulse_q   <= 1'b0;
      blink_q   <= 1'b0;
      secs_q    <= TURN_RELOAD;
      hold_q    <= '0;
      presc_q   <= '0;
      lock_q    <= '0;
      strikes_q <= '{default: 2'd0};
      sync_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q   <= state_d;
      player_q  <= player_d;
      winner_q  <= winner_d;
      pulse_q   <= pulse_d;
      blink_q   <= blink_d;
      secs_q    <= secs_d;
      hold_q    <= hold_d;
      presc_q   <= presc_d;
      lock_q    <= lock_d;
      strikes_q <= strikes_d;
      sync_q    <= {sync_q[1:0], btnC};
    end
  end

  // BCD digits come straight from the seconds register; minutes clip at 9.
  assign min_full     = secs_q / 8'd60;
  assign rem_sec      = secs_q % 8'd60;
  assign bcd_min      = (min_full > 8'd9) ? 4'd9 : min_full[3:0];
  assign bcd_sec_tens = 4'(rem_sec / 8'd10);
  assign bcd_sec_ones = 4'(rem_sec % 8'd10);

  always_comb begin
    led = 2'b00;
    unique case (state_q)
      RUN:       led[player_q] = 1'b1;
      EXPIRED:   led[player_q] = blink_q;
      GAME_OVER: led[winner_q] = 1'b1;
      default:   led = 2'b00;
    endcase
  end

  assign player        = player_q;
  assign seconds_left  = secs_q;
  assign timeout_pulse = pulse_q;
  assign strikes_p0    = strikes_q[0];
  assign strikes_p1    = strikes_q[1];
  assign game_over     = (state_q == GAME_OVER);
  assign winner        = winner_q;

endmodule
